axi_xbar: RTL and testbench

Address-decoding router between the core's single AXI-lite memory port (the arbitrated IFU/EXU/LSU channel) and two downstream targets: the SoC AXI4 `io_master` port and the local read-only CLINT. It accepts one outstanding transaction at a time, selects the target from the address, runs the full downstream handshake, buffers the response and returns it upstream. It also converts AXI-lite to single-beat AXI4 and checks the downstream response (ID/last).

---
 rtl/axi_xbar_if.sv | 88 ++++++++
 rtl/axi_xbar.sv | 130 +++++++++++++
 tb/tb_axi_xbar.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_xbar_if.sv
// axi_xbar_if: upstream AXI-lite, io_master AXI4 and CLINT read channels of the crossbar.
interface axi_xbar_if;
  logic [31:0] up_araddr_i;
  logic        up_arvalid_i;
  logic        up_arready_o;
  logic [31:0] up_rdata_o;
  logic [1:0]  up_rresp_o;
  logic        up_rvalid_o;
  logic        up_rready_i;
  logic [31:0] up_awaddr_i;
  logic        up_awvalid_i;
  logic        up_awready_o;
  logic [31:0] up_wdata_i;
  logic [3:0]  up_wstrb_i;
  logic        up_wvalid_i;
  logic        up_wready_o;
  logic [1:0]  up_bresp_o;
  logic        up_bvalid_o;
  logic        up_bready_i;
  logic        io_master_arvalid;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_arready;
  logic        io_master_rvalid;
  logic [31:0] io_master_rdata;
  logic [1:0]  io_master_rresp;
  logic        io_master_rlast;
  logic [3:0]  io_master_rid;
  logic        io_master_rready;
  logic        io_master_awvalid;
  logic [31:0] io_master_awaddr;
  logic [3:0]  io_master_awid;
  logic [7:0]  io_master_awlen;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst;
  logic        io_master_awready;
  logic        io_master_wvalid;
  logic [31:0] io_master_wdata;
  logic [3:0]  io_master_wstrb;
  logic        io_master_wlast;
  logic        io_master_wready;
  logic        io_master_bvalid;
  logic [1:0]  io_master_bresp;
  logic [3:0]  io_master_bid;
  logic        io_master_bready;
  logic [31:0] clint_araddr_o;
  logic        clint_arvalid_o;
  logic        clint_arready_i;
  logic [31:0] clint_rdata_i;
  logic [1:0]  clint_rresp_i;
  logic        clint_rvalid_i;
  logic        clint_rready_o;
  modport master (
    input  up_araddr_i, up_arvalid_i, up_rready_i, up_awaddr_i, up_awvalid_i,
           up_wdata_i, up_wstrb_i, up_wvalid_i, up_bready_i,
           io_master_arready, io_master_rvalid, io_master_rdata, io_master_rresp,
           io_master_rlast, io_master_rid, io_master_awready, io_master_wready,
           io_master_bvalid, io_master_bresp, io_master_bid,
           clint_arready_i, clint_rdata_i, clint_rresp_i, clint_rvalid_i,
    output up_arready_o, up_rdata_o, up_rresp_o, up_rvalid_o, up_awready_o,
           up_wready_o, up_bresp_o, up_bvalid_o,
           io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
           io_master_arsize, io_master_arburst, io_master_rready,
           io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen,
           io_master_awsize, io_master_awburst, io_master_wvalid, io_master_wdata,
           io_master_wstrb, io_master_wlast, io_master_bready,
           clint_araddr_o, clint_arvalid_o, clint_rready_o
  );
  modport slave (
    output up_araddr_i, up_arvalid_i, up_rready_i, up_awaddr_i, up_awvalid_i,
           up_wdata_i, up_wstrb_i, up_wvalid_i, up_bready_i,
           io_master_arready, io_master_rvalid, io_master_rdata, io_master_rresp,
           io_master_rlast, io_master_rid, io_master_awready, io_master_wready,
           io_master_bvalid, io_master_bresp, io_master_bid,
           clint_arready_i, clint_rdata_i, clint_rresp_i, clint_rvalid_i,
    input  up_arready_o, up_rdata_o, up_rresp_o, up_rvalid_o, up_awready_o,
           up_wready_o, up_bresp_o, up_bvalid_o,
           io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
           io_master_arsize, io_master_arburst, io_master_rready,
           io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen,
           io_master_awsize, io_master_awburst, io_master_wvalid, io_master_wdata,
           io_master_wstrb, io_master_wlast, io_master_bready,
           clint_araddr_o, clint_arvalid_o, clint_rready_o
  );
endinterface

// File: rtl/axi_xbar.sv
// axi_xbar: routes one AXI-lite transaction at a time to io_master (single-beat AXI4) or the read-only CLINT.
module axi_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_SIZE = 32'h0001_0000
) (
  input logic        clk_i,
  input logic        rst_i,
  axi_xbar_if.master bus
);
  typedef enum logic [2:0] {IDLE, R_REQ, R_WAIT, R_RESP, W_REQ, W_WAIT, W_RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  rresp_q, rresp_d, bresp_q, bresp_d;
  logic        clint_q, clint_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        run, idle;
  // 33-bit upper bound so a window touching the top of the address space cannot wrap
  function automatic logic in_clint(input logic [31:0] a);
    return a >= CLINT_BASE && {1'b0, a} < {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};
  endfunction
  assign run  = !rst_i;
  assign idle = run && state_q == IDLE;
  assign bus.up_arready_o      = idle;
  assign bus.up_awready_o      = idle && !bus.up_arvalid_i;
  assign bus.up_wready_o       = idle && !bus.up_arvalid_i;
  assign bus.up_rvalid_o       = run && state_q == R_RESP;
  assign bus.up_bvalid_o       = run && state_q == W_RESP;
  assign bus.up_rdata_o        = rdata_q;
  assign bus.up_rresp_o        = rresp_q;
  assign bus.up_bresp_o        = bresp_q;
  assign bus.io_master_arvalid = run && state_q == R_REQ && !clint_q;
  assign bus.clint_arvalid_o   = run && state_q == R_REQ && clint_q;
  assign bus.io_master_rready  = run && state_q == R_WAIT && !clint_q;
  assign bus.clint_rready_o    = run && state_q == R_WAIT && clint_q;
  assign bus.io_master_awvalid = run && state_q == W_REQ && !aw_done_q;
  assign bus.io_master_wvalid  = run && state_q == W_REQ && !w_done_q;
  assign bus.io_master_bready  = run && state_q == W_WAIT;
  assign bus.io_master_araddr  = addr_q;
  assign bus.io_master_awaddr  = addr_q;
  assign bus.clint_araddr_o    = addr_q;
  assign bus.io_master_wdata   = wdata_q;
  assign bus.io_master_wstrb   = wstrb_q;
  assign bus.io_master_wlast   = 1'b1;
  assign bus.io_master_arid    = 4'h0;
  assign bus.io_master_awid    = 4'h0;
  assign bus.io_master_arlen   = 8'h0;
  assign bus.io_master_awlen   = 8'h0;
  assign bus.io_master_arsize  = 3'b010;
  assign bus.io_master_awsize  = 3'b010;
  assign bus.io_master_arburst = 2'b01;
  assign bus.io_master_awburst = 2'b01;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    clint_d   = clint_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (bus.up_arvalid_i) begin
          addr_d  = bus.up_araddr_i;
          clint_d = in_clint(bus.up_araddr_i);
          state_d = R_REQ;
        end else if (bus.up_awvalid_i && bus.up_wvalid_i) begin
          addr_d    = bus.up_awaddr_i;
          wdata_d   = bus.up_wdata_i;
          wstrb_d   = bus.up_wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bresp_d   = in_clint(bus.up_awaddr_i) ? 2'b11 : bresp_q;
          state_d   = in_clint(bus.up_awaddr_i) ? W_RESP : W_REQ;
        end
      end
      R_REQ: state_d = (clint_q ? bus.clint_arready_i : bus.io_master_arready) ? R_WAIT : R_REQ;
      R_WAIT: begin
        if (clint_q && bus.clint_rvalid_i) begin
          rdata_d = bus.clint_rdata_i;
          rresp_d = bus.clint_rresp_i;
          state_d = R_RESP;
        end else if (!clint_q && bus.io_master_rvalid) begin
          rdata_d = bus.io_master_rdata;
          rresp_d = (bus.io_master_rid != 4'h0 || !bus.io_master_rlast) ? 2'b10 : bus.io_master_rresp;
          state_d = R_RESP;
        end
      end
      R_RESP: state_d = bus.up_rready_i ? IDLE : R_RESP;
      W_REQ: begin
        aw_done_d = aw_done_q || bus.io_master_awready;
        w_done_d  = w_done_q || bus.io_master_wready;
        state_d   = (aw_done_d && w_done_d) ? W_WAIT : W_REQ;
      end
      W_WAIT: begin
        bresp_d = bus.io_master_bvalid ? (bus.io_master_bid != 4'h0 ? 2'b10 : bus.io_master_bresp) : bresp_q;
        state_d = bus.io_master_bvalid ? W_RESP : W_WAIT;
      end
      W_RESP: state_d = bus.up_bready_i ? IDLE : W_RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      bresp_q   <= '0;
      clint_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
      clint_q   <= clint_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi_xbar.sv
// tb_axi_xbar: scenario tasks drive upstream and downstream sides; a response scoreboard checks data and latency.
module tb_axi_xbar;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi_xbar_if bus ();
  axi_xbar dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int checks = 0;
  int passed = 0;
  typedef struct packed {logic [31:0] data; logic [1:0] resp;} rexp_t;
  rexp_t rq[$];
  logic [1:0] bq[$];
  int io_ar_cyc = 0, clint_ar_cyc = 0, io_aw_cyc = 0, io_w_cyc = 0;
  // read-side downstream signals steered to whichever target the current read expects
  logic tclint = 1'b0, ds_arready = 1'b0, ds_rvalid = 1'b0, ds_rlast = 1'b1;
  logic [31:0] ds_rdata = '0;
  logic [1:0] ds_rresp = '0;
  logic [3:0] ds_rid = '0;
  logic ds_arvalid, other_arvalid, ds_rready;
  assign bus.io_master_arready = !tclint && ds_arready;
  assign bus.clint_arready_i   = tclint && ds_arready;
  assign bus.io_master_rvalid  = !tclint && ds_rvalid;
  assign bus.clint_rvalid_i    = tclint && ds_rvalid;
  assign bus.io_master_rdata   = ds_rdata;
  assign bus.clint_rdata_i     = ds_rdata;
  assign bus.io_master_rresp   = ds_rresp;
  assign bus.clint_rresp_i     = ds_rresp;
  assign bus.io_master_rid     = ds_rid;
  assign bus.io_master_rlast   = ds_rlast;
  assign ds_arvalid    = tclint ? bus.clint_arvalid_o : bus.io_master_arvalid;
  assign other_arvalid = tclint ? bus.io_master_arvalid : bus.clint_arvalid_o;
  assign ds_rready     = tclint ? bus.clint_rready_o : bus.io_master_rready;
  always @(posedge clk) begin
    #2;
    if (bus.io_master_arvalid) io_ar_cyc++;
    if (bus.clint_arvalid_o) clint_ar_cyc++;
    if (bus.io_master_awvalid) io_aw_cyc++;
    if (bus.io_master_wvalid) io_w_cyc++;
  end
  function automatic logic [11:0] handshakes();
    return {bus.up_arready_o, bus.up_awready_o, bus.up_wready_o, bus.up_rvalid_o, bus.up_bvalid_o,
            bus.io_master_arvalid, bus.io_master_rready, bus.io_master_awvalid, bus.io_master_wvalid,
            bus.io_master_bready, bus.clint_arvalid_o, bus.clint_rready_o};
  endfunction

  task automatic rd(input logic [31:0] a, input logic cl, input int ar_wait, input logic [31:0] d,
                    input logic [1:0] rs, input logic [3:0] id, input logic last, input logic [1:0] exp_rs,
                    input int stall);
    rexp_t e;
    int lat, n;
    rq.push_back({d, exp_rs});
    tclint = cl;
    fork
      begin
        bus.up_araddr_i = a;
        bus.up_arvalid_i = 1'b1;
        checks++; if (bus.up_arready_o !== 1'b1) $display("FAIL rd_arready addr=%h got=%b exp=1", a, bus.up_arready_o); else passed++;
        @(negedge clk);
        bus.up_arvalid_i = 1'b0;
        lat = 1;
        while (!bus.up_rvalid_o && lat < 40) begin @(negedge clk); lat++; end
        checks++; if (lat !== 3 + ar_wait) $display("FAIL rd_latency addr=%h got=%0d exp=%0d", a, lat, 3 + ar_wait); else passed++;
        e = rq.pop_front();
        checks++; if ({bus.up_rdata_o, bus.up_rresp_o} !== e) $display("FAIL rd_data addr=%h got=%h/%b exp=%h/%b", a, bus.up_rdata_o, bus.up_rresp_o, e.data, e.resp); else passed++;
        repeat (stall) begin
          @(negedge clk);
          checks++; if (!bus.up_rvalid_o || {bus.up_rdata_o, bus.up_rresp_o} !== e) $display("FAIL rd_stall addr=%h got=%b %h exp=1 %h", a, bus.up_rvalid_o, bus.up_rdata_o, e.data); else passed++;
        end
        bus.up_rready_i = 1'b1;
        @(negedge clk);
        bus.up_rready_i = 1'b0;
        checks++; if ({bus.up_rvalid_o, bus.up_arready_o} !== 2'b01) $display("FAIL rd_done addr=%h got=%b exp=01", a, {bus.up_rvalid_o, bus.up_arready_o}); else passed++;
      end
      begin
        n = 0;
        while (!ds_arvalid && n < 40) begin @(negedge clk); n++; end
        checks++; if ({ds_arvalid, other_arvalid} !== 2'b10 || (cl ? bus.clint_araddr_o : bus.io_master_araddr) !== a) $display("FAIL rd_route addr=%h got=%b exp=10", a, {ds_arvalid, other_arvalid}); else passed++;
        repeat (ar_wait) begin
          ds_rvalid = 1'b1;
          ds_rdata = ~d;
          @(negedge clk);
          checks++; if ({ds_arvalid, ds_rready} !== 2'b10) $display("FAIL rd_ar_hold addr=%h got=%b exp=10", a, {ds_arvalid, ds_rready}); else passed++;
        end
        ds_arready = 1'b1;
        @(negedge clk);
        ds_arready = 1'b0;
        ds_rvalid = 1'b1;
        ds_rdata = d;
        ds_rresp = rs;
        ds_rid = id;
        ds_rlast = last;
        checks++; if (ds_rready !== 1'b1) $display("FAIL rd_rready addr=%h got=%b exp=1", a, ds_rready); else passed++;
        @(negedge clk);
        ds_rvalid = 1'b0;
        ds_rid = 4'h0;
        ds_rlast = 1'b1;
        ds_rresp = 2'b00;
      end
    join
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic cl,
                    input int aw_wait, input int w_wait, input logic [3:0] bid, input logic [1:0] brs,
                    input logic [1:0] exp_rs);
    logic [1:0] e;
    int lat, n, m;
    m = aw_wait > w_wait ? aw_wait : w_wait;
    bq.push_back(exp_rs);
    fork
      begin
        bus.up_awaddr_i = a;
        bus.up_wdata_i = d;
        bus.up_wstrb_i = s;
        bus.up_awvalid_i = 1'b1;
        bus.up_wvalid_i = 1'b1;
        checks++; if ({bus.up_awready_o, bus.up_wready_o} !== 2'b11) $display("FAIL wr_ready addr=%h got=%b exp=11", a, {bus.up_awready_o, bus.up_wready_o}); else passed++;
        @(negedge clk);
        bus.up_awvalid_i = 1'b0;
        bus.up_wvalid_i = 1'b0;
        lat = 1;
        while (!bus.up_bvalid_o && lat < 40) begin @(negedge clk); lat++; end
        checks++; if (lat !== (cl ? 1 : 3 + m)) $display("FAIL wr_latency addr=%h got=%0d exp=%0d", a, lat, cl ? 1 : 3 + m); else passed++;
        e = bq.pop_front();
        checks++; if (bus.up_bresp_o !== e) $display("FAIL wr_bresp addr=%h got=%b exp=%b", a, bus.up_bresp_o, e); else passed++;
        bus.up_bready_i = 1'b1;
        @(negedge clk);
        bus.up_bready_i = 1'b0;
        checks++; if ({bus.up_bvalid_o, bus.up_arready_o} !== 2'b01) $display("FAIL wr_done addr=%h got=%b exp=01", a, {bus.up_bvalid_o, bus.up_arready_o}); else passed++;
      end
      if (!cl) begin
        n = 0;
        while (!(bus.io_master_awvalid || bus.io_master_wvalid) && n < 40) begin @(negedge clk); n++; end
        checks++; if ({bus.io_master_awaddr, bus.io_master_wdata, bus.io_master_wstrb, bus.io_master_wlast} !== {a, d, s, 1'b1}) $display("FAIL wr_fields addr=%h got=%h %h %b exp=%h %h %b", a, bus.io_master_awaddr, bus.io_master_wdata, bus.io_master_wstrb, a, d, s); else passed++;
        for (int t = 0; t <= m; t++) begin
          checks++; if ({bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready} !== {t <= aw_wait, t <= w_wait, 1'b0}) $display("FAIL wr_valids t=%0d got=%b exp=%b", t, {bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready}, {t <= aw_wait, t <= w_wait, 1'b0}); else passed++;
          bus.io_master_awready = (t == aw_wait);
          bus.io_master_wready = (t == w_wait);
          @(negedge clk);
        end
        bus.io_master_awready = 1'b0;
        bus.io_master_wready = 1'b0;
        bus.io_master_bvalid = 1'b1;
        bus.io_master_bid = bid;
        bus.io_master_bresp = brs;
        checks++; if (bus.io_master_bready !== 1'b1) $display("FAIL wr_bready addr=%h got=%b exp=1", a, bus.io_master_bready); else passed++;
        @(negedge clk);
        bus.io_master_bvalid = 1'b0;
        bus.io_master_bid = 4'h0;
      end
    join
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (handshakes() !== 12'h0) $display("FAIL reset_handshakes got=%b exp=0", handshakes()); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus.up_arready_o, bus.up_rvalid_o, bus.up_bvalid_o, bus.io_master_arvalid, bus.clint_arvalid_o} !== 5'b10000) $display("FAIL reset_release got=%b exp=10000", {bus.up_arready_o, bus.up_rvalid_o, bus.up_bvalid_o, bus.io_master_arvalid, bus.clint_arvalid_o}); else passed++;
    checks++; if ({bus.up_rdata_o, bus.up_rresp_o, bus.up_bresp_o} !== 36'h0) $display("FAIL reset_buffers got=%h exp=0", {bus.up_rdata_o, bus.up_rresp_o, bus.up_bresp_o}); else passed++;
    checks++; if ({bus.io_master_arid, bus.io_master_arlen, bus.io_master_arsize, bus.io_master_arburst, bus.io_master_awid, bus.io_master_awlen, bus.io_master_awsize, bus.io_master_awburst, bus.io_master_wlast} !== {4'h0, 8'h0, 3'b010, 2'b01, 4'h0, 8'h0, 3'b010, 2'b01, 1'b1}) $display("FAIL axi4_constants got=%h", {bus.io_master_arid, bus.io_master_arlen, bus.io_master_arsize, bus.io_master_arburst}); else passed++;
  endtask

  task automatic test_read_io();
    int c0 = clint_ar_cyc;
    rd(32'h8000_0000, 1'b0, 0, 32'hDEAD_BEEF, 2'b00, 4'h0, 1'b1, 2'b00, 0);
    rd(32'h0201_0000, 1'b0, 0, 32'h1357_9BDF, 2'b01, 4'h0, 1'b1, 2'b01, 2);
    rd(32'h01FF_FFFC, 1'b0, 1, 32'h0BAD_F00D, 2'b00, 4'h0, 1'b0, 2'b10, 0);
    checks++; if (clint_ar_cyc !== c0) $display("FAIL io_read_clint_quiet got=%0d exp=%0d", clint_ar_cyc, c0); else passed++;
  endtask

  task automatic test_read_clint();
    int i0 = io_ar_cyc;
    rd(32'h0200_BFF8, 1'b1, 4, 32'h0000_1234, 2'b00, 4'h5, 1'b1, 2'b00, 1);
    rd(32'h0200_FFFC, 1'b1, 0, 32'h5555_AAAA, 2'b01, 4'h0, 1'b1, 2'b01, 0);
    checks++; if (io_ar_cyc !== i0) $display("FAIL clint_read_io_quiet got=%0d exp=%0d", io_ar_cyc, i0); else passed++;
  endtask

  task automatic test_write();
    int a0 = io_aw_cyc, w0 = io_w_cyc;
    wr(32'h8000_0010, 32'hA5A5_A5A5, 4'b0011, 1'b0, 1, 4, 4'h0, 2'b00, 2'b00);
    checks++; if ({io_aw_cyc - a0, io_w_cyc - w0} !== {32'd2, 32'd5}) $display("FAIL wr_valid_cycles got=%0d/%0d exp=2/5", io_aw_cyc - a0, io_w_cyc - w0); else passed++;
    wr(32'h9000_0000, 32'h0123_4567, 4'b1111, 1'b0, 2, 0, 4'h1, 2'b00, 2'b10);
    wr(32'h01FF_FFFC, 32'hCAFE_0001, 4'b1000, 1'b0, 0, 0, 4'h0, 2'b01, 2'b01);
  endtask

  task automatic test_write_clint();
    int a0 = io_aw_cyc, w0 = io_w_cyc;
    wr(32'h0200_0000, 32'hFFFF_0000, 4'b1111, 1'b1, 0, 0, 4'h0, 2'b00, 2'b11);
    checks++; if ({io_aw_cyc, io_w_cyc} !== {a0, w0}) $display("FAIL clint_write_quiet got=%0d/%0d exp=%0d/%0d", io_aw_cyc, io_w_cyc, a0, w0); else passed++;
  endtask

  task automatic test_priority();
    int a0 = io_aw_cyc;
    bus.up_awaddr_i = 32'h8000_0020;
    bus.up_wdata_i = 32'h7777_8888;
    bus.up_wstrb_i = 4'b1111;
    bus.up_awvalid_i = 1'b1;
    bus.up_wvalid_i = 1'b1;
    bus.up_araddr_i = 32'h8000_0040;
    bus.up_arvalid_i = 1'b1;
    #1;
    checks++; if ({bus.up_arready_o, bus.up_awready_o, bus.up_wready_o} !== 3'b100) $display("FAIL prio_readies got=%b exp=100", {bus.up_arready_o, bus.up_awready_o, bus.up_wready_o}); else passed++;
    rd(32'h8000_0040, 1'b0, 0, 32'h4444_3333, 2'b00, 4'h3, 1'b1, 2'b10, 0);
    checks++; if (io_aw_cyc !== a0) $display("FAIL prio_write_held got=%0d exp=%0d", io_aw_cyc, a0); else passed++;
    wr(32'h8000_0020, 32'h7777_8888, 4'b1111, 1'b0, 0, 0, 4'h0, 2'b00, 2'b00);
  endtask

  task automatic test_reset_mid();
    tclint = 1'b0;
    bus.up_araddr_i = 32'h8000_0100;
    bus.up_arvalid_i = 1'b1;
    @(negedge clk);
    bus.up_arvalid_i = 1'b0;
    ds_arready = 1'b1;
    @(negedge clk);
    ds_arready = 1'b0;
    checks++; if (ds_rready !== 1'b1) $display("FAIL mid_rwait got=%b exp=1", ds_rready); else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (handshakes() !== 12'h0) $display("FAIL mid_reset_handshakes got=%b exp=0", handshakes()); else passed++;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++; if ({bus.up_arready_o, bus.up_rvalid_o, bus.io_master_rready, bus.up_rdata_o} !== {3'b100, 32'h0}) $display("FAIL mid_no_stale got=%b %h exp=100 0", {bus.up_arready_o, bus.up_rvalid_o, bus.io_master_rready}, bus.up_rdata_o); else passed++;
    end
    rd(32'h0200_0004, 1'b1, 0, 32'h0000_00AB, 2'b00, 4'h0, 1'b1, 2'b00, 0);
  endtask

  initial begin
    bus.up_araddr_i = '0; bus.up_arvalid_i = 1'b0; bus.up_rready_i = 1'b0;
    bus.up_awaddr_i = '0; bus.up_awvalid_i = 1'b0; bus.up_wdata_i = '0;
    bus.up_wstrb_i = '0; bus.up_wvalid_i = 1'b0; bus.up_bready_i = 1'b0;
    bus.io_master_awready = 1'b0; bus.io_master_wready = 1'b0;
    bus.io_master_bvalid = 1'b0; bus.io_master_bresp = 2'b00; bus.io_master_bid = 4'h0;
    test_reset();
    test_read_io();
    test_read_clint();
    test_write();
    test_write_clint();
    test_priority();
    test_reset_mid();
    checks++; if (rq.size() + bq.size() !== 0) $display("FAIL scoreboard_drain got=%0d exp=0", rq.size() + bq.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=%0d/%0d exp=finish", passed, checks);
    $fatal(1, "watchdog");
  end
endmodule
